// File: rtl/crtc_config_loader_if.sv
// rtl/crtc_config_loader_if.sv - load control, CPU-side and CRTC-side bus bundle for the CRTC config loader
interface crtc_config_loader_if;
    logic       start_i;
    logic       mode_i;
    logic       cpu_wr_strobe_i;
    logic       cpu_cs_i;
    logic       cpu_rw_ni;
    logic       cpu_rs_i;
    logic [7:0] cpu_data_i;
    logic       crtc_wr_strobe_o;
    logic       crtc_cs_o;
    logic       crtc_rw_no;
    logic       crtc_rs_o;
    logic [7:0] crtc_data_o;
    logic       busy_o;
    logic       done_o;
    logic       conflict_o;

    // slave: the loader itself
    modport slave (
        input  start_i, mode_i,
        input  cpu_wr_strobe_i, cpu_cs_i, cpu_rw_ni, cpu_rs_i, cpu_data_i,
        output crtc_wr_strobe_o, crtc_cs_o, crtc_rw_no, crtc_rs_o, crtc_data_o,
        output busy_o, done_o, conflict_o
    );

    // master: whoever drives the CPU bus and load requests
    modport master (
        output start_i, mode_i,
        output cpu_wr_strobe_i, cpu_cs_i, cpu_rw_ni, cpu_rs_i, cpu_data_i,
        input  crtc_wr_strobe_o, crtc_cs_o, crtc_rw_no, crtc_rs_o, crtc_data_o,
        input  busy_o, done_o, conflict_o
    );
endinterface

// File: rtl/crtc_config_loader.sv
// rtl/crtc_config_loader.sv - writes a 14-register CRTC mode table in idle CPU bus slots
module crtc_config_loader (
    input  logic                 sys_clock_i,
    input  logic                 reset_ni,
    crtc_config_loader_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'd13;

    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic       mode_q, mode_d;
    logic       conflict_q, conflict_d;

    logic       slot;
    logic       cpu_crtc_write;

    function automatic logic [7:0] reg_value(input logic mode, input logic [3:0] idx);
        logic [7:0] v;
        v = 8'h00;
        if (!mode) begin
            case (idx)
                4'd0:    v = 8'd63;
                4'd1:    v = 8'd40;
                4'd2:    v = 8'd48;
                4'd3:    v = 8'h51;
                4'd4:    v = 8'd32;
                4'd5:    v = 8'd5;
                4'd6:    v = 8'd25;
                4'd7:    v = 8'd28;
                4'd8:    v = 8'd0;
                4'd9:    v = 8'd7;
                4'd10:   v = 8'd0;
                4'd11:   v = 8'd0;
                4'd12:   v = 8'h10;
                default: v = 8'h00;
            endcase
        end else begin
            case (idx)
                4'd0:    v = 8'd49;
                4'd1:    v = 8'd40;
                4'd2:    v = 8'd41;
                4'd3:    v = 8'h0F;
                4'd4:    v = 8'd40;
                4'd5:    v = 8'd5;
                4'd6:    v = 8'd25;
                4'd7:    v = 8'd33;
                4'd8:    v = 8'd0;
                4'd9:    v = 8'd7;
                4'd10:   v = 8'd0;
                4'd11:   v = 8'd0;
                4'd12:   v = 8'h10;
                default: v = 8'h00;
            endcase
        end
        return v;
    endfunction

    // A strobe with the CRTC deselected is a bus cycle the CPU is not using.
    assign slot           = ((state_q == ST_ADDR) || (state_q == ST_DATA)) &&
                            bus.cpu_wr_strobe_i && !bus.cpu_cs_i;
    assign cpu_crtc_write = bus.cpu_wr_strobe_i && bus.cpu_cs_i && !bus.cpu_rw_ni;

    always_ff @(posedge sys_clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= ST_IDLE;
            idx_q      <= 4'd0;
            mode_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            mode_q     <= mode_d;
            conflict_q <= conflict_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mode_d     = mode_q;
        conflict_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    mode_d  = bus.mode_i;
                    idx_d   = 4'd0;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (slot) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                // A CPU write may have moved the CRTC address pointer; re-send the address.
                if (cpu_crtc_write) begin
                    state_d    = ST_ADDR;
                    conflict_d = 1'b1;
                end else if (slot) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = ST_ADDR;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.crtc_wr_strobe_o = bus.cpu_wr_strobe_i;
        bus.crtc_cs_o        = bus.cpu_cs_i;
        bus.crtc_rw_no       = bus.cpu_rw_ni;
        bus.crtc_rs_o        = bus.cpu_rs_i;
        bus.crtc_data_o      = bus.cpu_data_i;
        if (slot) begin
            bus.crtc_wr_strobe_o = 1'b1;
            bus.crtc_cs_o        = 1'b1;
            bus.crtc_rw_no       = 1'b0;
            if (state_q == ST_ADDR) begin
                bus.crtc_rs_o   = 1'b0;
                bus.crtc_data_o = {4'b0000, idx_q};
            end else begin
                bus.crtc_rs_o   = 1'b1;
                bus.crtc_data_o = reg_value(mode_q, idx_q);
            end
        end
        bus.busy_o     = (state_q == ST_ADDR) || (state_q == ST_DATA);
        bus.done_o     = (state_q == ST_DONE);
        bus.conflict_o = conflict_q;
    end

endmodule
